// File: rtl/debounce_pkg.sv
// Shared types and defaults for the multi-channel button debouncer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package debounce_pkg;

    localparam int DEF_HIST_LEN      = 8;
    localparam int DEF_LONG_CYCLES   = 64;
    localparam int DEF_REPEAT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } ch_state_e;

    // Width of a counter that must hold every value up to max(a, b).
    function automatic int clog2_max(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/debounce_array_if.sv
// Bundle of raw button inputs and per-channel debounced level/event outputs.
// Latency: none (wiring only).
// Backpressure: none; all outputs are level or single-cycle pulses.
interface debounce_array_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] buttons;
    logic [NUM_CH-1:0] debounced;
    logic [NUM_CH-1:0] press;
    logic [NUM_CH-1:0] release_pulse;
    logic [NUM_CH-1:0] long_press;
    logic [NUM_CH-1:0] repeat_pulse;
    logic              any_pressed;

    // Board / stimulus side: drives buttons, observes events.
    modport master (
        output buttons,
        input  debounced,
        input  press,
        input  release_pulse,
        input  long_press,
        input  repeat_pulse,
        input  any_pressed
    );

    // Debouncer side.
    modport slave (
        input  buttons,
        output debounced,
        output press,
        output release_pulse,
        output long_press,
        output repeat_pulse,
        output any_pressed
    );
endinterface

// File: rtl/debounce_channel.sv
// One debounced button: sync, history filter, level, press/release, long-press and auto-repeat.
// Latency: a stable input changes the level HIST_LEN+2 edges after it is first sampled.
// Backpressure: none; events are single-cycle pulses that are never held off.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int HIST_LEN      = DEF_HIST_LEN,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit REPEAT_EN     = 1'b1,
    parameter bit INVERT        = 1'b0
) (
    input  logic slow_clk,
    input  logic reset,
    input  logic raw_in,
    output logic debounced,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int            CW        = clog2_max(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [HIST_LEN-1:0] hist_q, hist_d;
    logic                deb_q, deb_d;
    logic                press_q, press_d;
    logic                rel_q, rel_d;
    logic                long_q, long_d;
    logic                rpt_q, rpt_d;
    ch_state_e           state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic rise;
    logic fall;

    // Input conditioning, history shift and debounced level with edge events.
    always_comb begin
        sync1_d = raw_in ^ INVERT;
        sync2_d = sync1_q;
        hist_d  = {hist_q[HIST_LEN-2:0], sync2_q};
        // Level only moves on unanimous history; mixed history holds it.
        rise    = (&hist_q) & ~deb_q;
        fall    = (~|hist_q) & deb_q;
        deb_d   = deb_q;
        if (rise) begin
            deb_d = 1'b1;
        end else if (fall) begin
            deb_d = 1'b0;
        end
        press_d = rise;
        rel_d   = fall;
    end

    // Hold-time FSM: long-press after LONG_CYCLES, then periodic repeats.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        long_d  = 1'b0;
        rpt_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (REPEAT_EN) begin
                    if (cnt_q == REP_LAST) begin
                        cnt_d = '0;
                        rpt_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset clears everything without emitting a release.
    always_ff @(posedge slow_clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= '0;
            deb_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            rpt_q   <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            deb_q   <= deb_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            rpt_q   <= rpt_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign debounced     = deb_q;
    assign press         = press_q;
    assign release_pulse = rel_q;
    assign long_press    = long_q;
    assign repeat_pulse  = rpt_q;

endmodule

// File: rtl/debounce_array.sv
// NUM_CH independent debounced buttons plus a combined any-pressed flag.
// Latency: HIST_LEN+2 edges input to level; any_pressed adds none over the level register.
// Backpressure: none; every channel may pulse in the same cycle.
module debounce_array
    import debounce_pkg::*;
#(
    parameter int              NUM_CH        = 4,
    parameter int              HIST_LEN      = DEF_HIST_LEN,
    parameter int              LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int              REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit              REPEAT_EN     = 1'b1,
    parameter logic [NUM_CH-1:0] ACTIVE_LOW  = '0
) (
    input  logic             slow_clk,
    input  logic             reset,
    debounce_array_if.slave  bus
);

    wire [NUM_CH-1:0] deb_w;
    wire [NUM_CH-1:0] press_w;
    wire [NUM_CH-1:0] rel_w;
    wire [NUM_CH-1:0] long_w;
    wire [NUM_CH-1:0] rpt_w;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .HIST_LEN      (HIST_LEN),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .REPEAT_EN     (REPEAT_EN),
            .INVERT        (ACTIVE_LOW[i])
        ) u_ch (
            .slow_clk      (slow_clk),
            .reset         (reset),
            .raw_in        (bus.buttons[i]),
            .debounced     (deb_w[i]),
            .press         (press_w[i]),
            .release_pulse (rel_w[i]),
            .long_press    (long_w[i]),
            .repeat_pulse  (rpt_w[i])
        );
    end

    assign bus.debounced     = deb_w;
    assign bus.press         = press_w;
    assign bus.release_pulse = rel_w;
    assign bus.long_press    = long_w;
    assign bus.repeat_pulse  = rpt_w;
    assign bus.any_pressed   = |deb_w;

endmodule

// File: tb/tb_debounce_array.sv
// Bench for debounce_array: directed scenarios with literal expectations plus a random phase,
// every cycle compared against a window/age based behavioural model.
// Two DUTs share the inputs: one with auto-repeat, one without.
module tb_debounce_array;

    localparam int         NCH = 4;
    localparam int         HL  = 8;
    localparam int         LC  = 64;
    localparam int         RC  = 16;
    localparam logic [3:0] ACT = 4'b1000;
    localparam logic [3:0] IDLE_BTN = 4'b1000;

    logic       slow_clk = 1'b0;
    logic       reset;
    logic [3:0] buttons;

    always #5 slow_clk = ~slow_clk;

    debounce_array_if #(.NUM_CH(NCH)) bus0 ();
    debounce_array_if #(.NUM_CH(NCH)) bus1 ();

    assign bus0.buttons = buttons;
    assign bus1.buttons = buttons;

    debounce_array #(
        .NUM_CH(NCH), .HIST_LEN(HL), .LONG_CYCLES(LC), .REPEAT_CYCLES(RC),
        .REPEAT_EN(1'b1), .ACTIVE_LOW(ACT)
    ) u_rep (
        .slow_clk (slow_clk),
        .reset    (reset),
        .bus      (bus0)
    );

    debounce_array #(
        .NUM_CH(NCH), .HIST_LEN(HL), .LONG_CYCLES(LC), .REPEAT_CYCLES(RC),
        .REPEAT_EN(1'b0), .ACTIVE_LOW(ACT)
    ) u_norep (
        .slow_clk (slow_clk),
        .reset    (reset),
        .bus      (bus1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The level after edge n is decided by the conditioned samples taken at
    // edges n-3 .. n-HL-2: unanimous ones -> pressed, unanimous zeros -> released.
    // A press lasting "age" edges fires long_press at age LC, repeats every RC after.
    bit         smp [NCH][HL+3];
    logic [3:0] m_deb [2];
    logic [3:0] m_press [2];
    logic [3:0] m_rel [2];
    logic [3:0] m_long [2];
    logic [3:0] m_rpt [2];
    int         age [2][NCH];
    bit         model_valid = 1'b0;
    bit         rep_en [2] = '{1'b1, 1'b0};

    always @(posedge slow_clk) begin
        for (int c = 0; c < NCH; c++) begin
            for (int j = HL + 2; j > 0; j--) smp[c][j] = smp[c][j-1];
            smp[c][0] = buttons[c] ^ ACT[c];
        end
        if (reset) begin
            for (int c = 0; c < NCH; c++)
                for (int j = 0; j < HL + 3; j++) smp[c][j] = 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_deb[d] = '0; m_press[d] = '0; m_rel[d] = '0;
                m_long[d] = '0; m_rpt[d] = '0;
                for (int c = 0; c < NCH; c++) age[d][c] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < NCH; c++) begin
                    bit all1, all0, oldv, newv;
                    all1 = 1'b1; all0 = 1'b1;
                    for (int j = 3; j < HL + 3; j++) begin
                        if (smp[c][j]) all0 = 1'b0;
                        else           all1 = 1'b0;
                    end
                    oldv = m_deb[d][c];
                    newv = all1 ? 1'b1 : (all0 ? 1'b0 : oldv);
                    m_press[d][c] = newv & ~oldv;
                    m_rel[d][c]   = ~newv & oldv;
                    m_long[d][c]  = 1'b0;
                    m_rpt[d][c]   = 1'b0;
                    if (newv && !oldv) begin
                        age[d][c] = 0;
                    end else if (newv && oldv) begin
                        age[d][c]++;
                        m_long[d][c] = (age[d][c] == LC);
                        m_rpt[d][c]  = rep_en[d] && (age[d][c] > LC) && (((age[d][c] - LC) % RC) == 0);
                    end
                    m_deb[d][c] = newv;
                end
            end
        end
        model_valid = 1'b1;
    end

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge slow_clk) begin
        if (model_valid) begin
            chk("rep debounced",   int'(bus0.debounced),     int'(m_deb[0]));
            chk("rep press",       int'(bus0.press),         int'(m_press[0]));
            chk("rep release",     int'(bus0.release_pulse), int'(m_rel[0]));
            chk("rep long_press",  int'(bus0.long_press),    int'(m_long[0]));
            chk("rep repeat",      int'(bus0.repeat_pulse),  int'(m_rpt[0]));
            chk("rep any_pressed", int'(bus0.any_pressed),   int'(|m_deb[0]));
            chk("norep debounced",   int'(bus1.debounced),     int'(m_deb[1]));
            chk("norep press",       int'(bus1.press),         int'(m_press[1]));
            chk("norep release",     int'(bus1.release_pulse), int'(m_rel[1]));
            chk("norep long_press",  int'(bus1.long_press),    int'(m_long[1]));
            chk("norep repeat",      int'(bus1.repeat_pulse),  int'(m_rpt[1]));
            chk("norep any_pressed", int'(bus1.any_pressed),   int'(|m_deb[1]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge slow_clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seen;
        int pe, li, lnr, re, nr;
        int reps[$];
        logic [3:0] lvl;
        int thr;

        reset   = 1'b1;
        buttons = IDLE_BTN;
        cyc(3);
        reset = 1'b0;
        cyc(20);
        chk("idle outputs rep", int'({bus0.debounced, bus0.press, bus0.release_pulse,
                                     bus0.long_press, bus0.repeat_pulse, bus0.any_pressed}), 0);

        // Reset in the middle of a hold: level drops, no release pulse.
        buttons[0] = 1'b1;
        cyc(15);
        chk("t1 deb0 held", int'(bus0.debounced[0]), 1);
        reset = 1'b1;
        cyc(1);
        chk("t1 deb0 after reset", int'(bus0.debounced[0]), 0);
        chk("t1 no release", int'(bus0.release_pulse[0]), 0);
        reset   = 1'b0;
        buttons = IDLE_BTN;
        cyc(15);
        chk("t1 quiet after reset", int'(bus0.debounced), 0);

        // Press latency and release latency on ch0.
        buttons[0] = 1'b1;
        cyc(10);
        chk("t2 deb0 edge9", int'(bus0.debounced[0]), 0);
        cyc(1);
        chk("t2 press0 edge10", int'(bus0.press[0]), 1);
        chk("t2 deb0 edge10", int'(bus0.debounced[0]), 1);
        cyc(1);
        chk("t2 press0 one cycle", int'(bus0.press[0]), 0);
        cyc(18);
        buttons[0] = 1'b0;
        cyc(10);
        chk("t2 rel0 edge39", int'({bus0.debounced[0], bus0.release_pulse[0]}), 2);
        cyc(1);
        chk("t2 rel0 edge40", int'({bus0.debounced[0], bus0.release_pulse[0]}), 1);
        cyc(1);
        chk("t2 rel0 one cycle", int'(bus0.release_pulse[0]), 0);

        // Glitchy ch1 never reaches a unanimous history.
        seen = 0;
        for (int i = 0; i < 26; i++) begin
            buttons[1] = (i < 5) || (i >= 6 && i < 11);
            cyc(1);
            seen |= int'(bus0.debounced[1] | bus0.press[1] | bus0.release_pulse[1]);
        end
        chk("t3 glitch silent", seen, 0);

        // Long hold on ch2: long_press, repeats, release.
        pe = -1; li = -1; lnr = -1; re = -1; nr = 0;
        buttons[2] = 1'b1;
        for (int i = 0; i <= 140; i++) begin
            cyc(1);
            if (bus0.press[2])         pe = i;
            if (bus0.long_press[2])    li = i;
            if (bus1.long_press[2])    lnr = i;
            if (bus0.repeat_pulse[2])  reps.push_back(i);
            if (bus1.repeat_pulse[2])  nr++;
            if (bus0.release_pulse[2]) re = i;
            if (i == 119) buttons[2] = 1'b0;
        end
        chk("t4 press edge", pe, 10);
        chk("t4 long edge", li, 74);
        chk("t4 repeat count", reps.size(), 3);
        chk("t4 repeat1 edge", (reps.size() > 0) ? reps[0] : -1, 90);
        chk("t4 repeat2 edge", (reps.size() > 1) ? reps[1] : -1, 106);
        chk("t4 repeat3 edge", (reps.size() > 2) ? reps[2] : -1, 122);
        chk("t4 release edge", re, 130);
        chk("t5 norep long edge", lnr, 74);
        chk("t5 norep repeat count", nr, 0);

        // Simultaneous press on ch0 and active-low ch3.
        buttons[0] = 1'b1;
        buttons[3] = 1'b0;
        cyc(11);
        chk("t6 press pair", int'({bus0.press[3], bus0.press[0]}), 3);
        chk("t6 any after press", int'(bus0.any_pressed), 1);
        cyc(10);
        buttons[0] = 1'b0;
        cyc(11);
        chk("t6 ch0 released, any", int'({bus0.debounced[0], bus0.any_pressed}), 1);
        buttons[3] = 1'b1;
        cyc(10);
        chk("t6 any before ch3 release", int'(bus0.any_pressed), 1);
        cyc(1);
        chk("t6 any after both", int'({bus0.release_pulse[3], bus0.any_pressed}), 2);

        // Random phase with varying activity and rare resets.
        lvl = '0;
        for (int seg = 0; seg < 6; seg++) begin
            case ($urandom_range(0, 2))
                0:       thr = 4;
                1:       thr = 30;
                default: thr = 150;
            endcase
            for (int k = 0; k < 600; k++) begin
                for (int c = 0; c < NCH; c++) begin
                    if ($urandom_range(0, 999) < thr) lvl[c] = ~lvl[c];
                    buttons[c] = lvl[c] ^ ACT[c] ^ ($urandom_range(0, 99) < 4);
                end
                reset = ($urandom_range(0, 1499) == 0);
                cyc(1);
            end
        end
        reset = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
